// File: rtl/pop_button_conditioner.sv
// Front-panel button conditioner for the POP timer core: sync, debounce,
// step pulses with hold-to-repeat, pair interlock and load-defaults strobe.

module pop_btn_debounce #(
    parameter int CNT_WIDTH      = 21,
    parameter int DEBOUNCE       = 25000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);
    localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE - 1);

    logic                 norm;
    logic                 sync1;
    logic                 sync2;
    logic [CNT_WIDTH-1:0] cnt;

    assign norm = (BTN_ACTIVE_LOW != 0) ? ~raw : raw;

    // Counter measures how long sync has disagreed with the accepted level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= norm;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module pop_button_conditioner #(
    parameter int CNT_WIDTH      = 21,
    parameter int DEBOUNCE       = 25000,
    parameter int REPEAT_DELAY   = 1250000,
    parameter int REPEAT_PERIOD  = 250000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic clk_2M5,
    input  logic reset_n,
    input  logic btn_p2_plus_raw,
    input  logic btn_p2_minus_raw,
    input  logic btn_fp_plus_raw,
    input  logic btn_fp_minus_raw,
    input  logic btn_defaults_raw,
    output logic pieovertwo_plus,
    output logic pieovertwo_minus,
    output logic freeprecess_plus,
    output logic freeprecess_minus,
    output logic load_defaults
);
    localparam int NUM_BTN  = 5;
    localparam int NUM_STEP = 4;
    localparam int DEF_IDX  = 4;

    localparam logic [CNT_WIDTH-1:0] RD_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RP_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

    logic [NUM_BTN-1:0]  raw_vec;
    logic [NUM_BTN-1:0]  stable;
    logic [NUM_STEP-1:0] step_q;
    logic                def_d;
    logic                load_q;

    // Index order: pairs {0,1} and {2,3} are plus/minus of one channel.
    assign raw_vec = {btn_defaults_raw, btn_fp_minus_raw, btn_fp_plus_raw,
                      btn_p2_minus_raw, btn_p2_plus_raw};

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_deb
        pop_btn_debounce #(
            .CNT_WIDTH     (CNT_WIDTH),
            .DEBOUNCE      (DEBOUNCE),
            .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
        ) u_deb (
            .clk    (clk_2M5),
            .reset_n(reset_n),
            .raw    (raw_vec[b]),
            .stable (stable[b])
        );
    end

    for (genvar i = 0; i < NUM_STEP; i++) begin : g_step
        localparam int PARTNER = i ^ 1;

        logic                 eff;
        logic                 eff_d;
        logic                 rise;
        logic                 rep_hit;
        logic                 repeating;
        logic [CNT_WIDTH-1:0] rcnt;
        logic                 out_q;

        // A button only counts as pressed while its partner is released.
        assign eff     = stable[i] & ~stable[PARTNER];
        assign rise    = eff & ~eff_d;
        assign rep_hit = eff & eff_d & (rcnt == (repeating ? RP_LAST : RD_LAST));

        always_ff @(posedge clk_2M5) begin
            if (!reset_n) begin
                eff_d     <= 1'b0;
                repeating <= 1'b0;
                rcnt      <= '0;
                out_q     <= 1'b0;
            end else begin
                eff_d <= eff;
                if (!eff || rise) begin
                    rcnt      <= '0;
                    repeating <= 1'b0;
                end else if (rep_hit) begin
                    rcnt      <= '0;
                    repeating <= 1'b1;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
                out_q <= (rise | rep_hit) & ~stable[DEF_IDX];
            end
        end

        assign step_q[i] = out_q;
    end

    always_ff @(posedge clk_2M5) begin
        if (!reset_n) begin
            def_d  <= 1'b0;
            load_q <= 1'b1;
        end else begin
            def_d  <= stable[DEF_IDX];
            load_q <= stable[DEF_IDX] & ~def_d;
        end
    end

    assign pieovertwo_plus   = step_q[0];
    assign pieovertwo_minus  = step_q[1];
    assign freeprecess_plus  = step_q[2];
    assign freeprecess_minus = step_q[3];
    assign load_defaults     = load_q;
endmodule
